// File: rtl/slow_mem_pkg.sv
// slow_mem_pkg: shared state encoding, line geometry and LFSR constants for the slow memory responder.
package slow_mem_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   localparam int LINE_W = 128;
   localparam int OFFSET_W = 4;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/slow_mem_responder_if.sv
// slow_mem_responder_if: cache-to-memory line interface; master is the cache, slave the memory.
interface slow_mem_responder_if;
   import slow_mem_pkg::*;
   logic                   mem_read;
   logic                   mem_write;
   logic [31:OFFSET_W]     mem_addr;
   logic [LINE_W-1:0]      mem_wdata;
   logic [LINE_W-1:0]      mem_rdata;
   logic                   mem_ready;
   logic                   proto_err;
   modport master (output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata, mem_ready, proto_err);
   modport slave (input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata, mem_ready, proto_err);
endinterface

// File: rtl/slow_mem_lfsr.sv
// slow_mem_lfsr: free-running 16-bit Galois LFSR used to jitter response latency.
module slow_mem_lfsr
   import slow_mem_pkg::*;
(
   input  logic        clk,
   input  logic        proc_reset,
   output logic [15:0] out
);
   always_ff @(posedge clk or posedge proc_reset)
      if (proc_reset) out <= LFSR_SEED;
      else out <= (out >> 1) ^ (out[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/slow_mem_responder.sv
// slow_mem_responder: line-wide memory with fixed multi-cycle latency behind the cache line interface.
// Define SLOW_MEM_JITTER_EN to add 0..3 cycles of LFSR-driven latency jitter.
module slow_mem_responder
   import slow_mem_pkg::*;
#(
   parameter int IDX_W   = 10,
   parameter int LATENCY = 8
)(
   input logic                 clk,
   input logic                 proc_reset,
   slow_mem_responder_if.slave bus
);
   logic [LINE_W-1:0] mem [0:2**IDX_W-1];
   state_t            state;
   logic [7:0]        cnt;
   logic [7:0]        cnt_init;
   logic              op_wr;
   logic [IDX_W-1:0]  idx;
   logic [LINE_W-1:0] wdata_q;
   logic              complete;
`ifdef SLOW_MEM_JITTER_EN
   logic [15:0] lfsr;
   logic        unused_bits;
   slow_mem_lfsr u_lfsr (.clk(clk), .proc_reset(proc_reset), .out(lfsr));
   assign cnt_init = 8'(LATENCY - 1) + {6'd0, lfsr[1:0]};
   assign unused_bits = ^{bus.mem_addr[31:IDX_W+OFFSET_W], lfsr[15:2]};
`else
   logic unused_bits;
   assign cnt_init = 8'(LATENCY - 1);
   assign unused_bits = ^bus.mem_addr[31:IDX_W+OFFSET_W];
`endif
   assign complete = (state == BUSY) && (cnt == 8'd0);
   // Reset gates the write so an abort on the completing edge leaves the line untouched.
   always_ff @(posedge clk)
      if (complete && op_wr && !proc_reset) mem[idx] <= wdata_q;
   always_ff @(posedge clk or posedge proc_reset)
      if (proc_reset) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         op_wr         <= 1'b0;
         idx           <= '0;
         wdata_q       <= '0;
         bus.mem_ready <= 1'b0;
         bus.mem_rdata <= '0;
         bus.proto_err <= 1'b0;
      end else
         case (state)
            IDLE:
               if (bus.mem_read || bus.mem_write) begin
                  state         <= BUSY;
                  cnt           <= cnt_init;
                  op_wr         <= bus.mem_write;
                  idx           <= bus.mem_addr[IDX_W+OFFSET_W-1:OFFSET_W];
                  wdata_q       <= bus.mem_wdata;
                  bus.proto_err <= bus.proto_err | (bus.mem_read & bus.mem_write);
               end
            BUSY:
               if (cnt != 8'd0) cnt <= cnt - 8'd1;
               else begin
                  state         <= DONE;
                  bus.mem_ready <= 1'b1;
                  if (!op_wr) bus.mem_rdata <= mem[idx];
               end
            default: begin
               state         <= IDLE;
               bus.mem_ready <= 1'b0;
            end
         endcase
endmodule

// File: tb/tb_slow_mem_responder.sv
// tb_slow_mem_responder: directed scoreboard bench for slow_mem_responder (IDX_W=10, LATENCY=8).
module tb_slow_mem_responder;
   import slow_mem_pkg::*;
   localparam int LAT = 8;
   logic clk = 1'b0;
   logic proc_reset;
   int   vectors = 0;
   int   errs = 0;
   logic [127:0] sb[$];
   logic [127:0] model [int];
   logic [127:0] last_rd;
   logic [127:0] pend_wd;
   int   pend_idx;
   bit   pend_rd;
   always #5 clk = ~clk;
   slow_mem_responder_if bus ();
   slow_mem_responder #(.IDX_W(10), .LATENCY(LAT)) dut (.clk(clk), .proc_reset(proc_reset), .bus(bus));
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic issue(input bit rd, input bit wr, input logic [31:4] addr, input logic [127:0] wd);
      @(posedge clk);
      #1;
      bus.mem_read = rd;
      bus.mem_write = wr;
      bus.mem_addr = addr;
      bus.mem_wdata = wd;
      pend_idx = int'(addr[13:4]);
      pend_wd = wd;
      pend_rd = rd & ~wr;
      if (pend_rd) sb.push_back(model[pend_idx]);
   endtask
   // Counts negedges from the request's first cycle until mem_ready, then checks the result.
   task automatic wait_ready(input bit toggle);
      int  k;
      bit  got;
      bit  ok;
      got = 1'b0;
      k = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.mem_ready) begin
            got = 1'b1;
            k = i;
         end else if (toggle && i > 0) begin
            bus.mem_addr = 28'($urandom);
            bus.mem_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
      end
`ifdef SLOW_MEM_JITTER_EN
      ok = got && k >= LAT + 1 && k <= LAT + 4;
`else
      ok = got && k == LAT + 1;
`endif
      chk("latency", 128'(ok), 128'(1));
      if (got) begin
         if (pend_rd) begin
            chk("rdata", bus.mem_rdata, sb.size() > 0 ? sb.pop_front() : 128'hx);
            last_rd = bus.mem_rdata;
         end else begin
            chk("rdata_hold", bus.mem_rdata, last_rd);
            model[pend_idx] = pend_wd;
         end
      end
   endtask
   task automatic release_req();
      @(posedge clk);
      #1;
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      @(negedge clk);
      chk("ready_pulse", 128'(bus.mem_ready), 128'(0));
   endtask
   initial begin
      bit seen;
      proc_reset = 1'b1;
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr = '0;
      bus.mem_wdata = '0;
      last_rd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 128'(bus.mem_ready), 128'(0));
      chk("rst_rdata", bus.mem_rdata, 128'(0));
      chk("rst_proto", 128'(bus.proto_err), 128'(0));
      chk("rst_state", 128'(dut.state), 128'(IDLE));
      @(posedge clk);
      #1 proc_reset = 1'b0;
      // Write then read back the same line.
      issue(1'b0, 1'b1, 28'h0000010, 128'hDEADBEEF_00000000_00000000_00000001);
      wait_ready(1'b0);
      release_req();
      issue(1'b1, 1'b0, 28'h0000010, '0);
      wait_ready(1'b0);
      release_req();
      // Held read: one pulse per acceptance, re-accepted right after DONE.
      issue(1'b1, 1'b0, 28'h0000010, '0);
      wait_ready(1'b0);
      sb.push_back(model[pend_idx]);
      wait_ready(1'b0);
      release_req();
      // Aliasing: 0x400 lands on index 0; inputs churn during BUSY.
      issue(1'b0, 1'b1, 28'h0000400, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      wait_ready(1'b1);
      release_req();
      issue(1'b1, 1'b0, 28'h0000000, '0);
      wait_ready(1'b0);
      release_req();
      // Both read and write: treated as a write, sticky proto_err.
      issue(1'b1, 1'b1, 28'h0000003, 128'hCAFE_F00D_0000_0003_1111_2222_3333_4444);
      wait_ready(1'b0);
      release_req();
      chk("proto_set", 128'(bus.proto_err), 128'(1));
      issue(1'b1, 1'b0, 28'h0000003, '0);
      wait_ready(1'b0);
      release_req();
      chk("proto_sticky", 128'(bus.proto_err), 128'(1));
      // Reset in the middle of a write must abort it.
      issue(1'b0, 1'b1, 28'h0000005, 128'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555);
      wait_ready(1'b0);
      release_req();
      issue(1'b0, 1'b1, 28'h0000005, 128'h1234_0000_0000_0000_0000_0000_0000_9876);
      repeat (4) @(negedge clk);
      proc_reset = 1'b1;
      #1;
      chk("abort_ready", 128'(bus.mem_ready), 128'(0));
      chk("abort_proto", 128'(bus.proto_err), 128'(0));
      chk("abort_rdata", bus.mem_rdata, 128'(0));
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         seen |= bus.mem_ready;
      end
      chk("abort_no_ready", 128'(seen), 128'(0));
      bus.mem_write = 1'b0;
      @(posedge clk);
      #1 proc_reset = 1'b0;
      last_rd = '0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         seen |= bus.mem_ready;
      end
      chk("idle_no_ready", 128'(seen), 128'(0));
      issue(1'b1, 1'b0, 28'h0000005, '0);
      wait_ready(1'b0);
      release_req();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
